// File: rtl/cdc1_gray_sync_if.sv
// Bundle for the Gray-code synchronizer: the source-side bus d and the
// synchronized outputs observed in the destination clock domain.
interface cdc1_gray_sync_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] bin_out;
    logic             chg;
    logic             err;

    modport master (
        output d,
        input  out,
        input  bin_out,
        input  chg,
        input  err
    );

    modport slave (
        input  d,
        output out,
        output bin_out,
        output chg,
        output err
    );
endinterface

// File: rtl/cdc1_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded bus with registered binary decode,
// change pulse and sticky multi-bit-violation flag.
module cdc1_gray_sync #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    cdc1_gray_sync_if.slave bus
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("cdc1_gray_sync: STAGES must be in 2..4");
    end

    // Index 0 is the first flop, which samples d with no logic in front of it.
    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]             bin_q, bin_d;
    logic                         chg_q, chg_d;
    logic                         err_q, err_d;

    logic [WIDTH-1:0] next_g;
    logic [WIDTH-1:0] cur_g;

    assign next_g = sync_q[STAGES-2];
    assign cur_g  = sync_q[STAGES-1];

    // Decode and flags are formed from the value about to enter the last stage,
    // so they land on the same edge as out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bin
        assign bin_d[i] = ^next_g[WIDTH-1:i];
    end

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], bus.d};
        chg_d  = (next_g != cur_g);
        err_d  = err_q | ($countones(next_g ^ cur_g) > 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            bin_q  <= '0;
            chg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            bin_q  <= bin_d;
            chg_q  <= chg_d;
            err_q  <= err_d;
        end
    end

    assign bus.out     = cur_g;
    assign bus.bin_out = bin_q;
    assign bus.chg     = chg_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_cdc1_gray_sync.sv
// Scoreboard bench for cdc1_gray_sync: every value the destination edge samples
// is turned into an expected (out, bin, err, cycle) record checked on chg.
module tb_cdc1_gray_sync;

    localparam int W = 2;
    localparam int S = 2;

    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] b;
        logic         e;
        int unsigned  t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int unsigned checks;
    int unsigned failures;

    exp_t         q[$];
    logic [W-1:0] lp;
    logic         errm;

    cdc1_gray_sync_if #(.WIDTH(W)) bus ();

    cdc1_gray_sync #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < W; i++) b = b ^ (g >> i);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: value present on d at a destination edge reaches out S-1 edges later.
    task automatic sampled(input logic [W-1:0] v);
        exp_t e;
        if (v != lp) begin
            if ($countones(v ^ lp) > 1) errm = 1'b1;
            e.g = v;
            e.b = g2b(v);
            e.e = errm;
            e.t = cyc + S;
            q.push_back(e);
            lp = v;
        end
    endtask

    // One destination cycle: glitch value a at +5, settled value b at +15.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #5 bus.d = a;
        #10 bus.d = b;
        sampled(b);
    endtask

    task automatic hold(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(bus.d, bus.d);
    endtask

    task automatic do_reset(input logic [W-1:0] dval, input int unsigned ncyc);
        @(posedge clk);
        #5 rst_n = 1'b0;
        q.delete();
        lp   = '0;
        errm = 1'b0;
        #1;
        check("rst_now_out", 32'(bus.out), 32'd0);
        check("rst_now_err", 32'(bus.err), 32'd0);
        bus.d = dval;
        repeat (ncyc) @(posedge clk);
        #5 rst_n = 1'b1;
        sampled(bus.d);
    endtask

    // Monitor: pops on every chg pulse; otherwise outputs must be stable.
    initial begin : monitor
        logic [W-1:0] cur_g;
        logic         cur_e;
        exp_t         e;
        cur_g = '0;
        cur_e = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out", 32'(bus.out), 32'd0);
                check("rst_bin", 32'(bus.bin_out), 32'd0);
                check("rst_chg", 32'(bus.chg), 32'd0);
                check("rst_err", 32'(bus.err), 32'd0);
                cur_g = '0;
                cur_e = 1'b0;
            end else if (bus.chg) begin
                if (q.size() == 0) begin
                    check("spurious_chg", 32'(bus.chg), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out", 32'(bus.out), 32'(e.g));
                    check("bin_out", 32'(bus.bin_out), 32'(e.b));
                    check("err", 32'(bus.err), 32'(e.e));
                    check("latency_cycle", cyc, e.t);
                    cur_g = e.g;
                    cur_e = e.e;
                end
            end else begin
                check("stable_out", 32'(bus.out), 32'(cur_g));
                check("stable_bin", 32'(bus.bin_out), 32'(g2b(cur_g)));
                check("stable_err", 32'(bus.err), 32'(cur_e));
            end
        end
    end

    initial begin : stim
        logic [W-1:0] nv;
        checks   = 0;
        failures = 0;
        lp       = '0;
        errm     = 1'b0;
        rst_n    = 1'b0;
        bus.d    = 2'b11;
        #1;
        check("por_out", 32'(bus.out), 32'd0);
        check("por_bin", 32'(bus.bin_out), 32'd0);
        check("por_chg", 32'(bus.chg), 32'd0);
        check("por_err", 32'(bus.err), 32'd0);
        repeat (3) @(posedge clk);
        #5 bus.d = 2'b00;
        @(posedge clk);
        #5 rst_n = 1'b1;
        sampled(bus.d);
        hold(2);

        // Basic latency and ordered sequence.
        step(2'b01, 2'b01);
        hold(3);
        step(2'b00, 2'b00); hold(3);
        step(2'b10, 2'b10); hold(3);
        step(2'b00, 2'b00); hold(3);

        // Source changing twice per destination cycle.
        step(2'b01, 2'b01);
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        step(2'b10, 2'b10);
        step(2'b10, 2'b00);
        hold(3);

        // Wrap-around transitions.
        step(2'b10, 2'b10); hold(2);
        step(2'b00, 2'b00); hold(2);

        // Multi-bit violation, then err must stick.
        step(2'b11, 2'b11); hold(2);
        step(2'b10, 2'b10); hold(2);
        step(2'b00, 2'b00); hold(2);

        // Reset one cycle after d changes, d returned to 00 during reset.
        step(2'b01, 2'b01);
        do_reset(2'b00, 2);
        hold(4);
        // Same, but d still holds the new value on release.
        step(2'b01, 2'b01);
        do_reset(2'b01, 2);
        hold(4);

        // Randomized single-bit Gray walk with random glitches and holds.
        for (int i = 0; i < 300; i++) begin
            nv = bus.d;
            if ($urandom_range(0, 2) != 0) nv = nv ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 3) == 0) step(W'($urandom_range(0, (1 << W) - 1)), nv);
            else step(nv, nv);
            if ($urandom_range(0, 19) == 0) do_reset(W'($urandom_range(0, (1 << W) - 1)), 1);
        end

        hold(S + 3);
        check("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
